// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the receive and transmit paths.
//   DATA_BITS  : payload bits per frame (8N1, LSB first)
//   IDX_W      : width of a bit index within the payload
//   rx_state_t : receiver frame-tracking states
//   half_count : bit-timer count at which a bit centre is reached
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Integer division keeps the centre sample on or just before the true middle.
  function automatic int half_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter for the UART receiver.
//   clk       in  system clock
//   rst       in  async reset, active-high
//   clr       in  force the count back to 0 on the next edge
//   half_tick out count == (CLKS_PER_BIT-1)/2, the centre of a bit started at count 0
//   full_tick out count == CLKS_PER_BIT-1; the counter wraps to 0 on the next edge
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_count(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == HALF);
  assign full_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_msg.sv
// uart_rx_msg: UART 8N1 receiver with a one-entry holding register.
//   clk       in  system clock, rising edge
//   nRst      in  async reset, active-high (1 = reset)
//   rx_serial in  serial line, idle high, asynchronous to clk
//   rx_ready  in  consumer takes rx_byte this cycle when rx_valid=1
//   rx_byte   out received byte, stable while rx_valid=1
//   rx_valid  out holding register full
//   frame_err out one-cycle pulse: stop bit sampled low, byte discarded
//   overrun   out one-cycle pulse: byte completed while holding register full, byte dropped
//   rx_busy   out receiver is in any state other than IDLE
module uart_rx_msg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 sync_p0;
  logic                 rxs;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 tmr_clr;
  logic                 half_tick;
  logic                 full_tick;
  logic                 sample_bit;
  logic                 stop_ok;
  logic                 stop_bad;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 dlv_p;

  // Stage p0/p1: two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= rx_serial;
      rxs     <= sync_p0;
    end
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (nRst),
    .clr      (tmr_clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The timer is held at 0 in IDLE so that START measures from the detected edge,
  // and is cleared again at the start-bit centre so every later full_tick is a bit centre.
  always_comb begin
    state_nxt  = state;
    tmr_clr    = 1'b0;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (half_tick) begin
          tmr_clr   = 1'b1;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          sample_bit = 1'b1;
          if (idx == LAST_IDX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rxs) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        tmr_clr = 1'b1;
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      idx <= '0;
    end else if ((state == START) && half_tick) begin
      idx <= '0;
    end else if (sample_bit) begin
      idx <= idx + 1'b1;
    end
  end

  // Stage p2: payload shift register (LSB first, written by index)
  always_ff @(posedge clk) begin
    if (sample_bit) shift[idx] <= rxs;
  end

  // Stage p3: deliver cycle follows the stop-bit sample; holding register and flag pulses
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      dlv_p <= 1'b0;
    end else begin
      dlv_p <= stop_ok;
    end
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= dlv_p && rx_valid && !rx_ready;
      // A consumer take and a new delivery in the same cycle swap bytes without a bubble.
      if (dlv_p && (!rx_valid || rx_ready)) begin
        rx_byte  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_msg.sv
// tb_uart_rx_msg: directed and randomized frames driven onto rx_serial; accepted bytes,
// flag pulses and valid cycles are collected and compared against expected values.
module tb_uart_rx_msg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int vcyc = 0;
  int fe = 0;
  int ov = 0;
  int both = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  uart_rx_msg #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .rx_serial(rx_serial),
    .rx_ready (rx_ready),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_byte);
    if (rx_valid) vcyc++;
    if (frame_err) fe++;
    if (overrun) ov++;
    if (frame_err && overrun) both++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] g;
    g = 8'hxx;
    if (got.size() > 0) g = got.pop_front();
    checks++;
    assert (g === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, g, exp);
    end
  endtask

  // One 8N1 frame starting now. stop_low>0 holds the stop bit low that many clocks first;
  // rp raises rx_ready for exactly cycle rp of the frame; abort_at asserts reset at that cycle.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int rp,
                            input int abort_at);
    for (int i = 0; i < 144; i++) begin
      if (i == abort_at) begin
        nRst      = 1'b1;
        rx_serial = 1'b1;
        rx_ready  = 1'b0;
        return;
      end
      rx_serial = (i < 16) ? 1'b0 : b[(i - 16) / 16];
      if (i == rp) rx_ready = 1'b1;
      else if (i == rp + 1) rx_ready = 1'b0;
      tick(1);
    end
    if (stop_low > 0) begin
      rx_serial = 1'b0;
      tick(stop_low - 1);
      check("wait_idle_busy", 32'(rx_busy), 32'd1);
      tick(1);
    end
    for (int i = 144; i < 160; i++) begin
      rx_serial = 1'b1;
      if (i == rp) rx_ready = 1'b1;
      else if (i == rp + 1) rx_ready = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    int b_v;
    int b_fe;
    int b_ov;
    logic [7:0] rb;
    logic [7:0] lb[3];

    tick(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_byte", 32'(rx_byte), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    nRst = 1'b0;
    tick(5);

    // Single frame, consumer always ready: one-cycle valid pulse
    rx_ready = 1'b1;
    b_v = vcyc; b_fe = fe; b_ov = ov;
    send_frame(8'hA5, 0, -10, -1);
    tick(4);
    check("a5_valid_cycles", 32'(vcyc - b_v), 32'd1);
    check("a5_count", 32'(got.size()), 32'd1);
    expect_byte("a5_byte", 8'hA5);
    check("a5_ferr", 32'(fe - b_fe), 32'd0);
    check("a5_ovr", 32'(ov - b_ov), 32'd0);

    // Back-to-back loopback bytes
    lb[0] = 8'h3C; lb[1] = 8'h00; lb[2] = 8'hFF;
    for (int k = 0; k < 3; k++) send_frame(lb[k], 0, -10, -1);
    tick(4);
    check("loop_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) expect_byte("loop_byte", lb[k]);

    // Short low glitch on idle line
    b_v = vcyc; b_fe = fe;
    rx_serial = 1'b0;
    tick(5);
    check("glitch_busy_start", 32'(rx_busy), 32'd1);
    rx_serial = 1'b1;
    tick(30);
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    check("glitch_valid", 32'(vcyc - b_v), 32'd0);
    check("glitch_ferr", 32'(fe - b_fe), 32'd0);

    // Framing error: stop bit held low 40 clocks, then a good frame
    b_v = vcyc; b_fe = fe;
    send_frame(8'h55, 40, -10, -1);
    tick(4);
    check("ferr_pulse", 32'(fe - b_fe), 32'd1);
    check("ferr_valid", 32'(vcyc - b_v), 32'd0);
    check("ferr_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 0, -10, -1);
    tick(4);
    expect_byte("after_ferr_byte", 8'h12);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    b_ov = ov;
    send_frame(8'h11, 0, -10, -1);
    send_frame(8'h22, 0, -10, -1);
    tick(4);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_held_byte", 32'(rx_byte), 32'h11);
    check("ovr_pulse", 32'(ov - b_ov), 32'd1);
    check("ovr_none_taken", 32'(got.size()), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    expect_byte("ovr_take", 8'h11);
    check("ovr_cleared", 32'(rx_valid), 32'd0);

    // Take and deliver in the same cycle (deliver cycle = frame cycle 155)
    b_ov = ov;
    send_frame(8'h11, 0, -10, -1);
    send_frame(8'h22, 0, 155, -1);
    tick(4);
    check("swap_valid", 32'(rx_valid), 32'd1);
    check("swap_byte", 32'(rx_byte), 32'h22);
    check("swap_no_ovr", 32'(ov - b_ov), 32'd0);
    expect_byte("swap_taken_old", 8'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    expect_byte("swap_take_new", 8'h22);

    // Reset mid-frame with a byte already held
    send_frame(8'h5A, 0, -10, -1);
    tick(4);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    send_frame(8'h77, 0, -10, 60);
    tick(1);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_byte", 32'(rx_byte), 32'd0);
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    tick(2);
    nRst = 1'b0;
    tick(5);
    rx_ready = 1'b1;
    send_frame(8'h81, 0, -10, -1);
    tick(4);
    check("post_rst_count", 32'(got.size()), 32'd1);
    expect_byte("post_rst_byte", 8'h81);

    // Randomized bytes with random idle gaps (0 = back-to-back)
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      expq.push_back(rb);
      send_frame(rb, 0, -10, -1);
      rx_serial = 1'b1;
      tick($urandom_range(0, 20));
    end
    tick(4);
    check("rand_count", 32'(got.size()), 32'(expq.size()));
    while (expq.size() > 0) expect_byte("rand_byte", expq.pop_front());

    check("flags_overlap", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
